mat3_stream_loader: RTL

- Streaming front/back end for the combinational 3x3 Q4.12 matrix multiplier.
- Collects 18 elements one per handshake: 9 of A, then 9 of B, both row-major.
- Drives the multiplier's flattened A/B buses, captures its flattened C result once, then serializes C out one element per handshake.
- Sits between the element-stream source (inversion control path) and the downstream consumer of the product.

---
 rtl/mat3_pkg.sv | 17 +
 rtl/mat3_drain_ser.sv | 68 ++++++
 rtl/mat3_stream_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mat3_pkg.sv
// Shared types and constants for the 3x3 Q4.12 matrix stream loader.
package mat3_pkg;

    localparam int DATA_W = 16;
    localparam int DIM    = 3;
    localparam int NE     = DIM * DIM;
    localparam int FRAC_W = 12;

    typedef logic signed [DATA_W-1:0] elem_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/mat3_drain_ser.sv
// Holds the captured product matrix and serializes it one element per handshake.
// Optional synchronous clear input exists only when MAT3_STREAM_SOFT_CLR_EN is defined.
module mat3_drain_ser #(
    parameter int DATA_W = 16,
    parameter int NE     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef MAT3_STREAM_SOFT_CLR_EN
    input  logic                 clr,
`endif
    input  logic                 start,
    input  logic [DATA_W*NE-1:0] mul_c,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 done
);
    import mat3_pkg::*;

    localparam int IDX_W = $clog2(NE);

    logic [DATA_W*NE-1:0] c_buf_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 valid_reg;
    logic                 handshake;

    assign handshake = valid_reg & out_ready;
    assign out_valid = valid_reg;
    assign out_last  = valid_reg && (idx_reg == IDX_W'(NE - 1));
    assign out_data  = c_buf_reg[int'(idx_reg) * DATA_W +: DATA_W];
    assign done      = handshake && (idx_reg == IDX_W'(NE - 1));

    // The buffer is only ever loaded by start; the clear leaves it intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_buf_reg <= '0;
        end else if (start) begin
            c_buf_reg <= mul_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end
`ifdef MAT3_STREAM_SOFT_CLR_EN
        else if (clr) begin
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end
`endif
        else if (start) begin
            idx_reg   <= '0;
            valid_reg <= 1'b1;
        end else if (handshake) begin
            if (idx_reg == IDX_W'(NE - 1)) begin
                idx_reg   <= '0;
                valid_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mat3_stream_loader.sv
// Streams 18 elements (A then B, row-major) into the multiplier buses, captures C, drains it.
// Optional soft_clr port is enabled by defining MAT3_STREAM_SOFT_CLR_EN.
module mat3_stream_loader #(
    parameter int DATA_W = 16,
    parameter int DIM    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef MAT3_STREAM_SOFT_CLR_EN
    input  logic                        soft_clr,
`endif
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic [DATA_W*DIM*DIM-1:0]   mat_a,
    output logic [DATA_W*DIM*DIM-1:0]   mat_b,
    input  logic [DATA_W*DIM*DIM-1:0]   mul_c,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        busy
);
    import mat3_pkg::*;

    localparam int NE    = DIM * DIM;
    localparam int CNT_W = $clog2(2 * NE);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             accept;
    logic             drain_start;
    logic             drain_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        in_ready    = 1'b0;
        accept      = 1'b0;
        drain_start = 1'b0;
        case (state_reg)
            LOAD: begin
                // Held low during reset so nothing is offered before release.
                in_ready = ~rst;
                accept   = in_valid & ~rst;
                if (accept) begin
                    if (cnt_reg == CNT_W'(2 * NE - 1)) begin
                        cnt_next   = '0;
                        state_next = CAPTURE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            CAPTURE: begin
                drain_start = 1'b1;
                state_next  = DRAIN;
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
`ifdef MAT3_STREAM_SOFT_CLR_EN
        // The clear wins over any handshake in the same cycle; that element is dropped.
        if (soft_clr) begin
            state_next  = LOAD;
            cnt_next    = '0;
            accept      = 1'b0;
            drain_start = 1'b0;
        end
`endif
    end

    assign busy = (state_reg == CAPTURE) || (state_reg == DRAIN);

    // Each element owns its register; counter value selects which one loads.
    for (genvar gi = 0; gi < NE; gi++) begin : g_elem
        logic [DATA_W-1:0] a_reg;
        logic [DATA_W-1:0] b_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_reg <= '0;
                b_reg <= '0;
            end else if (accept) begin
                if (cnt_reg == CNT_W'(gi)) begin
                    a_reg <= in_data;
                end
                if (cnt_reg == CNT_W'(gi + NE)) begin
                    b_reg <= in_data;
                end
            end
        end

        assign mat_a[gi*DATA_W +: DATA_W] = a_reg;
        assign mat_b[gi*DATA_W +: DATA_W] = b_reg;
    end

    mat3_drain_ser #(
        .DATA_W (DATA_W),
        .NE     (NE)
    ) u_drain (
        .clk       (clk),
        .rst       (rst),
`ifdef MAT3_STREAM_SOFT_CLR_EN
        .clr       (soft_clr),
`endif
        .start     (drain_start),
        .mul_c     (mul_c),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (drain_done)
    );

endmodule
